// File: rtl/byte_stream_sched.sv
// byte_stream_sched: sequences one input block per start pulse in front of the
// byte-addressing unit, arbitrating shift steps (S) against dword reads (D).
// Optional feature macro: BYTE_SCHED_RR_EN (round-robin arbitration; default is
// fixed priority D over S).
module byte_stream_sched #(
  parameter int unsigned LEN_W       = 32,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned FLUSH_CYC   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_blk_len,
  input  logic             i_abort,
  input  logic             i_sh_req,
  output logic             o_sh_gnt,
  input  logic             i_dw_req,
  output logic             o_dw_gnt,
  output logic             o_byte4_en,
  output logic             o_rd_shift_en,
  output logic             o_rd_dword_en,
  input  logic             i_byte4_busy,
  input  logic             i_byte4_svalid,
  input  logic             i_byte4_dvalid,
  output logic [LEN_W-1:0] o_bytes_left,
  output logic             o_blk_done,
  output logic             o_blk_err
);

  localparam int unsigned CntMax = (ACK_TIMEOUT > FLUSH_CYC) ? ACK_TIMEOUT : FLUSH_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StArm, StServe, StShift, StDword, StFlush, StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [LEN_W-1:0] r_bytes_left;
  logic             r_blk_err;
  logic             w_pick_dw;
  logic             w_ack;
  logic             w_tmo_hit;
  logic             w_flush_end;
  logic             w_counting;

  // Acknowledge for whichever strobe is currently out.
  assign w_ack = (r_state == StShift) ? i_byte4_svalid : i_byte4_dvalid;

  // Watchdog fires on the last allowed strobe cycle without an ack; abort takes precedence.
  assign w_tmo_hit = ((r_state == StShift) || (r_state == StDword)) && !w_ack && !i_abort &&
                     (r_cnt == CntW'(ACK_TIMEOUT - 1));
  assign w_flush_end = (r_cnt == CntW'(FLUSH_CYC - 1));
  assign w_counting  = (r_state == StShift) || (r_state == StDword) || (r_state == StFlush);

`ifdef BYTE_SCHED_RR_EN
  logic r_last_dw;

  // With both requests pending, D wins only if S was granted last.
  assign w_pick_dw = i_dw_req && (!i_sh_req || !r_last_dw);

  // Last-grant pointer; starts at S so the first contested grant goes to D.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_dw <= 1'b0;
    end else if (o_sh_gnt) begin
      r_last_dw <= 1'b0;
    end else if (o_dw_gnt) begin
      r_last_dw <= 1'b1;
    end
  end
`else
  // Fixed priority: literal copy drains first.
  assign w_pick_dw = i_dw_req;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_nxt = (i_blk_len == '0) ? StFlush : StArm;
      end
      StArm: begin
        if (i_abort)            w_state_nxt = StFlush;
        else if (!i_byte4_busy) w_state_nxt = StServe;
      end
      StServe: begin
        if (i_abort)                   w_state_nxt = StFlush;
        else if (r_bytes_left == '0)   w_state_nxt = StFlush;
        else if (w_pick_dw)            w_state_nxt = StDword;
        else if (i_sh_req)             w_state_nxt = StShift;
      end
      StShift, StDword: begin
        if (i_abort)        w_state_nxt = StFlush;
        else if (w_ack)     w_state_nxt = StServe;
        else if (w_tmo_hit) w_state_nxt = StFlush;
      end
      StFlush: begin
        if (w_flush_end) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs decoded from state; grants also need the ack and no coincident abort.
  always_comb begin
    o_byte4_en    = (r_state == StArm) || (r_state == StServe) ||
                    (r_state == StShift) || (r_state == StDword);
    o_rd_shift_en = (r_state == StShift);
    o_rd_dword_en = (r_state == StDword);
    o_sh_gnt      = (r_state == StShift) && i_byte4_svalid && !i_abort;
    o_dw_gnt      = (r_state == StDword) && i_byte4_dvalid && !i_abort;
    o_blk_done    = (r_state == StDone);
  end

  // Byte counter, sticky error and the shared watchdog/flush cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bytes_left <= '0;
      r_blk_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (r_state == StIdle && i_start) begin
        r_bytes_left <= i_blk_len;
        r_blk_err    <= 1'b0;
      end else if (o_sh_gnt) begin
        r_bytes_left <= r_bytes_left - LEN_W'(1);
      end else if (o_dw_gnt) begin
        r_bytes_left <= (r_bytes_left < LEN_W'(4)) ? '0 : r_bytes_left - LEN_W'(4);
      end
      if (w_tmo_hit) r_blk_err <= 1'b1;
      // Counter restarts on every state entry so each strobe/flush phase is timed alone.
      if (w_state_nxt != r_state || !w_counting) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_bytes_left = r_bytes_left;
  assign o_blk_err    = r_blk_err;

endmodule

// File: tb/tb_byte_stream_sched.sv
// Bench for byte_stream_sched: directed block scenarios plus randomized blocks
// against a behavioural model of byte accounting and arbitration order.
module tb_byte_stream_sched;

  localparam int LEN_W       = 32;
  localparam int ACK_TIMEOUT = 64;
  localparam int FLUSH_CYC   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [LEN_W-1:0] blk_len = '0;
  logic             sh_req = 1'b0, dw_req = 1'b0;
  logic             busy = 1'b0, svalid = 1'b0, dvalid = 1'b0;
  logic             sh_gnt, dw_gnt, en, rse, rde, done, err;
  logic [LEN_W-1:0] bytes_left;

  byte_stream_sched #(
    .LEN_W      (LEN_W),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .FLUSH_CYC  (FLUSH_CYC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_blk_len     (blk_len),
    .i_abort       (abort),
    .i_sh_req      (sh_req),
    .o_sh_gnt      (sh_gnt),
    .i_dw_req      (dw_req),
    .o_dw_gnt      (dw_gnt),
    .o_byte4_en    (en),
    .o_rd_shift_en (rse),
    .o_rd_dword_en (rde),
    .i_byte4_busy  (busy),
    .i_byte4_svalid(svalid),
    .i_byte4_dvalid(dvalid),
    .o_bytes_left  (bytes_left),
    .o_blk_done    (done),
    .o_blk_err     (err)
  );

  int n_checks = 0, n_fail = 0;
  // Model / environment state
  int track = 0, exp_left = 0;
  int sh_budget = 0, dw_budget = 0, rnd_req = 0;
  int ack_lat = 1, rnd_ack = 0, ack_wait = 0, busy_left = 0;
  int sh_cnt = 0, dw_cnt = 0, done_cnt = 0, low_run = 0, en_seen = 0;
  int rse_cycles = 0, rde_starts = 0, prev_rde = 0;
  int abort_on_ack = 0, abort_stage = 0, abort_fired = 0;
  bit grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: unit responder at +1, observation and requesters at +2.
  task automatic step();
    @(posedge clk);
    #1;
    if (abort) abort = 1'b0;
    svalid = 1'b0;
    dvalid = 1'b0;
    if (rse || rde) begin
      if (ack_wait >= ack_lat) begin
        if (rse) svalid = 1'b1;
        else     dvalid = 1'b1;
        ack_wait = 0;
        if (rnd_ack != 0) ack_lat = $urandom_range(0, 3);
        if (abort_on_ack != 0) begin
          abort = 1'b1;
          abort_on_ack = 0;
          abort_stage = 1;
          abort_fired++;
        end
      end else begin
        ack_wait++;
      end
    end else begin
      ack_wait = 0;
    end
    busy = en && (busy_left > 0);
    if (busy) busy_left--;
    #1;
    chk("strobe_excl", 32'(rse & rde), 0);
    chk("grant_excl", 32'(sh_gnt & dw_gnt), 0);
    if (track != 0) chk("bytes_left", bytes_left, exp_left);
    if (abort_stage == 2) begin
      chk("abort_en_low", 32'(en), 0);
      abort_stage = 0;
    end else if (abort_stage == 1) begin
      abort_stage = 2;
    end
    if (en) begin en_seen = 1; low_run = 0; end
    else low_run++;
    if (rse) rse_cycles++;
    if (rde && prev_rde == 0) rde_starts++;
    prev_rde = int'(rde);
    if (sh_gnt) begin
      chk("sh_gnt_req", 32'(sh_req), 1);
      chk("sh_gnt_ack", 32'(svalid), 1);
      exp_left = exp_left - 1;
      sh_cnt++;
      grants.push_back(1'b0);
      sh_budget--;
      if (sh_budget <= 0 || rnd_req != 0) sh_req = 1'b0;
    end
    if (dw_gnt) begin
      chk("dw_gnt_req", 32'(dw_req), 1);
      chk("dw_gnt_ack", 32'(dvalid), 1);
      exp_left = exp_left - ((exp_left < 4) ? exp_left : 4);
      dw_cnt++;
      grants.push_back(1'b1);
      dw_budget--;
      if (dw_budget <= 0 || rnd_req != 0) dw_req = 1'b0;
    end
    if (done) begin
      done_cnt++;
      chk("flush_gap", low_run, FLUSH_CYC + 1);
    end
    if (!sh_req && sh_budget > 0 && (rnd_req == 0 || $urandom_range(0, 2) == 0)) sh_req = 1'b1;
    if (!dw_req && dw_budget > 0 && (rnd_req == 0 || $urandom_range(0, 2) == 0)) dw_req = 1'b1;
  endtask

  task automatic start_block(input int len, input int busy_n);
    blk_len = LEN_W'(len);
    start = 1'b1;
    busy_left = busy_n;
    sh_cnt = 0; dw_cnt = 0; done_cnt = 0; en_seen = 0;
    rse_cycles = 0; rde_starts = 0; low_run = 0; track = 0;
    grants.delete();
    step();
    start = 1'b0;
    exp_left = len;
    track = 1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done_cnt, 1);
    step();
    step();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle_en"}, 32'(en), 0);
  endtask

  task automatic quiet_reqs();
    sh_budget = 0; dw_budget = 0; rnd_req = 0;
    sh_req = 1'b0; dw_req = 1'b0;
  endtask

  initial begin
    int left, drem, n;
    bit last, pick;
    bit expq[$];

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_en", 32'(en), 0);
    chk("rst_rse", 32'(rse), 0);
    chk("rst_rde", 32'(rde), 0);
    chk("rst_sh_gnt", 32'(sh_gnt), 0);
    chk("rst_dw_gnt", 32'(dw_gnt), 0);
    chk("rst_left", bytes_left, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    rnd_ack = 1;

    // T1: shifts only, plus an ignored start mid-block
    sh_budget = 1000;
    start_block(8, 2);
    n = 0;
    while (sh_cnt == 0 && n < 200) begin step(); n++; end
    blk_len = LEN_W'(99);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t1", 500);
    chk("t1_sh_cnt", sh_cnt, 8);
    chk("t1_dw_cnt", dw_cnt, 0);
    chk("t1_left", bytes_left, 0);
    chk("t1_err", 32'(err), 0);
    quiet_reqs();

    // T2: dwords only, 6 -> 2 -> 0
    dw_budget = 1000;
    start_block(6, 0);
    wait_done("t2", 500);
    chk("t2_dw_cnt", dw_cnt, 2);
    chk("t2_sh_cnt", sh_cnt, 0);
    chk("t2_strobes", rde_starts, 2);
    quiet_reqs();

    // T3: both held, D released after 3 grants
    sh_budget = 1000;
    dw_budget = 3;
    start_block(20, 1);
    wait_done("t3", 1000);
    left = 20; drem = 3; last = 1'b0;
    while (left > 0) begin
`ifdef BYTE_SCHED_RR_EN
      pick = (drem > 0) ? !last : 1'b0;
`else
      pick = (drem > 0);
`endif
      if (pick) begin
        left = left - ((left < 4) ? left : 4);
        drem--;
      end else begin
        left--;
      end
      expq.push_back(pick);
      last = pick;
    end
    chk("t3_ngrants", grants.size(), expq.size());
    for (int i = 0; i < expq.size() && i < grants.size(); i++)
      chk($sformatf("t3_grant%0d", i), 32'(grants[i]), 32'(expq[i]));
    quiet_reqs();

    // T4: shift ack withheld -> timeout, error, no grant
    rnd_ack = 0;
    ack_lat = 1000;
    sh_budget = 1;
    start_block(5, 0);
    wait_done("t4", 300);
    chk("t4_strobe_cycles", rse_cycles, ACK_TIMEOUT);
    chk("t4_err", 32'(err), 1);
    chk("t4_sh_cnt", sh_cnt, 0);
    quiet_reqs();
    ack_lat = 1;
    rnd_ack = 1;
    dw_budget = 1;
    start_block(3, 0);
    chk("t4_err_clr", 32'(err), 0);
    wait_done("t4b", 300);
    chk("t4b_dw_cnt", dw_cnt, 1);
    quiet_reqs();

    // T5: abort coincident with dword ack
    rnd_ack = 0;
    ack_lat = 2;
    dw_budget = 1;
    abort_on_ack = 1;
    abort_fired = 0;
    start_block(8, 0);
    wait_done("t5", 300);
    chk("t5_abort_fired", abort_fired, 1);
    chk("t5_dw_cnt", dw_cnt, 0);
    chk("t5_err", 32'(err), 0);
    quiet_reqs();

    // T6: reset mid-shift, then a zero-length block
    ack_lat = 1000;
    sh_budget = 1000;
    start_block(10, 0);
    n = 0;
    while (!rse && n < 50) begin step(); n++; end
    chk("t6_in_shift", 32'(rse), 1);
    step();
    rst = 1'b1;
    track = 0;
    step();
    chk("t6_rst_en", 32'(en), 0);
    chk("t6_rst_rse", 32'(rse), 0);
    chk("t6_rst_rde", 32'(rde), 0);
    chk("t6_rst_gnt", 32'(sh_gnt | dw_gnt), 0);
    chk("t6_rst_left", bytes_left, 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_err", 32'(err), 0);
    rst = 1'b0;
    quiet_reqs();
    ack_lat = 1;
    rnd_ack = 1;
    step();
    start_block(0, 0);
    wait_done("t6z", 50);
    chk("t6z_en_never", en_seen, 0);

    // Randomized blocks against the byte-accounting model
    for (int b = 0; b < 6; b++) begin
      rnd_req = 1;
      sh_budget = 1000;
      dw_budget = 1000;
      start_block($urandom_range(1, 30), $urandom_range(0, 3));
      wait_done("rnd", 2000);
      chk("rnd_left", bytes_left, 0);
      chk("rnd_err", 32'(err), 0);
      quiet_reqs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
